// File: rtl/switch_debouncer.sv
// Per-bit switch debouncer: 2-FF synchroniser and a tick-sampled stability counter per bit.
// Optional EDGE_PULSE_EN macro adds per-bit rise_pulse/fall_pulse outputs.
module switch_debouncer #(
  parameter int               WIDTH        = 18,
  parameter int               TICK_DIV     = 50000,
  parameter int               STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic             changed,
  output logic             tick
`ifdef EDGE_PULSE_EN
  ,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`endif
);

  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] update;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  generate
    if (TICK_DIV <= 1) begin : g_tick_every
      // Holds tick low while reset is asserted, then strobes every cycle.
      logic armed;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) armed <= 1'b0;
        else       armed <= 1'b1;
      end
      assign tick = armed;
    end else begin : g_presc
      localparam int PW = $clog2(TICK_DIV);
      localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
      logic [PW-1:0] presc;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                    presc <= '0;
        else if (presc == PRESC_LAST) presc <= '0;
        else                          presc <= presc + PW'(1);
      end
      assign tick = (presc == PRESC_LAST);
    end
  endgenerate

  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync2[i] == db_out[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CNT_LAST) begin
          cnt_nxt[i] = '0;
          update[i]  = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      db_out  <= RESET_VALUE;
      changed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      db_out  <= db_out ^ update;
      changed <= |update;
    end
  end

`ifdef EDGE_PULSE_EN
  // An updating bit always takes the synchronised level, so its direction is sync2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_pulse <= '0;
      fall_pulse <= '0;
    end else begin
      rise_pulse <= update & sync2;
      fall_pulse <= update & ~sync2;
    end
  end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3).
// Stimulus pushes expected db_out updates with a cycle window; a monitor checks each changed pulse.
module tb_switch_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw_in = 4'hF;
  logic [3:0] db_out;
  logic       changed;
  logic       tick;
`ifdef EDGE_PULSE_EN
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
`endif

  switch_debouncer #(
    .WIDTH(4), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_VALUE(4'h0)
  ) dut (
    .clk(clk),
    .reset(rst),
    .raw_in(raw_in),
    .db_out(db_out),
    .changed(changed),
    .tick(tick)
`ifdef EDGE_PULSE_EN
    ,
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] val;
    logic [3:0] rise;
    logic [3:0] fall;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] exp_db = 4'h0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] prev_db = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  task automatic push(input logic [3:0] val, input int lo, input int hi);
    exp_t e;
    e.val  = val;
    e.rise = val & ~exp_db;
    e.fall = ~val & exp_db;
    e.lo   = lo;
    e.hi   = hi;
    exp_db = val;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every changed pulse must match the head of the queue, inside its cycle window.
  always @(negedge clk) begin
    if (rst) begin
      prev_db = db_out;
    end else begin
      if (exp_q.size() > 0 && !changed && cyc > exp_q[0].hi) begin
        check("update_timeout", cyc, exp_q[0].hi);
        void'(exp_q.pop_front());
      end
      if (changed) begin
        if (exp_q.size() == 0) begin
          check("unexpected_changed", int'(db_out), int'(prev_db));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("db_out_on_change", int'(db_out), int'(e.val));
          check("latency_in_window", int'(cyc >= e.lo && cyc <= e.hi), 1);
`ifdef EDGE_PULSE_EN
          check("rise_pulse", int'(rise_pulse), int'(e.rise));
          check("fall_pulse", int'(fall_pulse), int'(e.fall));
`endif
        end
      end else begin
        check("db_out_stable_without_changed", int'(db_out), int'(prev_db));
`ifdef EDGE_PULSE_EN
        check("no_edge_pulse_idle", int'(rise_pulse | fall_pulse), 0);
`endif
      end
      prev_db = db_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int c_last;
    int r;
    int tk;

    // Reset state with raw_in=F held
    step(3);
    check("reset_db_out", int'(db_out), 0);
    check("reset_changed", int'(changed), 0);
    check("reset_tick", int'(tick), 0);

    // 1: release with F held; prescaler starts at 0 so expect exactly 12 clk
    rst = 1'b0;
    c = cyc;
    push(4'hF, c + 11, c + 14);
    step(20);

    tk = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      tk += int'(tick);
    end
    check("tick_count_40clk", tk, 10);

    raw_in = 4'h0;
    c = cyc;
    push(4'h0, c + 11, c + 14);
    step(20);

    // 2: bit0 bounces every 3 clk, ends high
    c_last = cyc;
    for (int k = 0; k < 13; k++) begin
      raw_in[0] = ~k[0];
      if (!k[0]) c_last = cyc;
      step(3);
    end
    check("bounce_db_out_low", int'(db_out), 0);
    push(4'h1, c_last + 11, c_last + 14);
    step(20);
    raw_in = 4'h0;
    c = cyc;
    push(4'h0, c + 11, c + 14);
    step(20);

    // 3: bit1 1-clk glitch, then high across exactly 2 ticks
    raw_in[1] = 1'b1;
    step(1);
    raw_in[1] = 1'b0;
    step(10);
    raw_in[1] = 1'b1;
    step(8);
    raw_in[1] = 1'b0;
    step(20);
    check("glitch_db_out_low", int'(db_out), 0);
    // A full-length press afterwards must still take the full count
    raw_in[1] = 1'b1;
    c = cyc;
    push(4'h2, c + 11, c + 14);
    step(20);
    raw_in = 4'h0;
    c = cyc;
    push(4'h0, c + 11, c + 14);
    step(20);

    // 4: multi-bit simultaneous update, both directions
    raw_in = 4'h5;
    c = cyc;
    push(4'h5, c + 11, c + 14);
    step(20);
    raw_in = 4'h0;
    c = cyc;
    push(4'h0, c + 11, c + 14);
    step(20);

    // 5: reset pulse after two disagreeing ticks on bit3
    raw_in = 4'h8;
    step(10);
    rst = 1'b1;
    step(1);
    check("midcount_reset_db_out", int'(db_out), 0);
    check("midcount_reset_changed", int'(changed), 0);
    rst = 1'b0;
    r = cyc;
    push(4'h8, r + 12, r + 12);
    step(20);
    raw_in = 4'h0;
    c = cyc;
    push(4'h0, c + 11, c + 14);
    step(20);

    // 6: bit2 up then down (edge pulses checked when built with EDGE_PULSE_EN)
    raw_in = 4'h4;
    c = cyc;
    push(4'h4, c + 11, c + 14);
    step(20);
    raw_in = 4'h0;
    c = cyc;
    push(4'h0, c + 11, c + 14);
    step(20);

    check("scoreboard_drained", exp_q.size(), 0);
    check("final_db_out", int'(db_out), int'(exp_db));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
